// File: rtl/capture_readout_if.sv
// Host/RAM-side bundle for the capture readout engine: start command, RAM read
// port and transmitter valid/ready stream.
interface capture_readout_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, start_ptr, count, ram_dout, tx_ready,
        input  ram_addr, tx_data, tx_valid, busy, done
    );

    modport slave (
        input  start, start_ptr, count, ram_dout, tx_ready,
        output ram_addr, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/capture_readout.sv
// Streams a circular window of the 128x8 capture RAM to the host transmitter.
// Build macro READOUT_CHECKSUM_EN appends an 8-bit running-sum byte after the samples.
module capture_readout #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    capture_readout_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
`ifdef READOUT_CHECKSUM_EN
    localparam logic [2:0] S_CSUM    = 3'd4;
`endif

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] ptr_q,      ptr_d;
    logic [ADDR_W:0]   rem_q,      rem_d;
    logic [DATA_W-1:0] tx_data_q,  tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
`ifdef READOUT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q,      sum_d;
`endif

    logic [ADDR_W:0] count_clamp_s;
    logic            accept_s;

    assign count_clamp_s = (bus.count > DEPTH_C) ? DEPTH_C : bus.count;
    assign accept_s      = tx_valid_q & bus.tx_ready;

    // Next-state and datapath decode for the fetch/capture/send walk.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef READOUT_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count == {(ADDR_W+1){1'b0}}) begin
`ifdef READOUT_CHECKSUM_EN
                        sum_d      = {DATA_W{1'b0}};
                        tx_data_d  = {DATA_W{1'b0}};
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = S_CSUM;
`else
                        done_d     = 1'b1;
`endif
                    end else begin
                        ptr_d   = bus.start_ptr;
                        rem_d   = count_clamp_s;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
`ifdef READOUT_CHECKSUM_EN
                        sum_d   = {DATA_W{1'b0}};
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            // RAM output now reflects the address presented during FETCH.
            S_CAPTURE: begin
                tx_data_d  = bus.ram_dout;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (accept_s) begin
                    ptr_d = ptr_q + PTR_ONE;
                    rem_d = rem_q - REM_ONE;
`ifdef READOUT_CHECKSUM_EN
                    sum_d = sum_q + tx_data_q;
`endif
                    if (rem_q == REM_ONE) begin
`ifdef READOUT_CHECKSUM_EN
                        tx_data_d = sum_q + tx_data_q;
                        state_d   = S_CSUM;
`else
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
`ifdef READOUT_CHECKSUM_EN
            S_CSUM: begin
                if (accept_s) begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            default: begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= {ADDR_W{1'b0}};
            rem_q      <= {(ADDR_W+1){1'b0}};
            tx_data_q  <= {DATA_W{1'b0}};
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            sum_q      <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef READOUT_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.ram_addr = ptr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_capture_readout.sv
// Scoreboard bench for capture_readout: a model RAM holds addr^0x5A, expected
// bytes are queued at START and compared against bytes accepted on the TX stream.
module tb_capture_readout;
`ifdef READOUT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [6:0] exp_a[$];
    logic [7:0] acc_q[$];
    logic [6:0] addr_q[$];
    int done_cnt  = 0;
    int busy_cyc  = 0;
    int valid_cyc = 0;
    int overlap   = 0;

    capture_readout_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    capture_readout dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model RAM with one clock of read latency.
    always @(posedge clk) bus.ram_dout <= {1'b0, bus.ram_addr} ^ 8'h5A;

    // Observe the stream half a cycle before each active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_valid && bus.tx_ready) begin
                acc_q.push_back(bus.tx_data);
                addr_q.push_back(bus.ram_addr);
            end
            if (bus.done)             done_cnt++;
            if (bus.busy)             busy_cyc++;
            if (bus.tx_valid)         valid_cyc++;
            if (bus.busy && bus.done) overlap++;
        end
    end

    task automatic clear_obs();
        acc_q.delete(); addr_q.delete(); exp_q.delete(); exp_a.delete();
        done_cnt = 0; busy_cyc = 0; valid_cyc = 0;
    endtask

    task automatic push_exp(input logic [6:0] ptr, input int n);
        logic [6:0] a;
        logic [7:0] s;
        a = ptr;
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, a} ^ 8'h5A);
            exp_a.push_back(a);
            s = s + ({1'b0, a} ^ 8'h5A);
            a = a + 7'd1;
        end
        if (CSUM_EN) begin
            exp_q.push_back(s);
            exp_a.push_back(a);
        end
    endtask

    task automatic pulse_start(input logic [6:0] ptr, input logic [7:0] cnt);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_ptr = ptr; bus.count = cnt;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.ram_addr, bus.tx_data, bus.tx_valid, bus.busy, bus.done} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_state: addr=%h data=%h valid=%b busy=%b done=%b, want all zero",
                     bus.ram_addr, bus.tx_data, bus.tx_valid, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        logic [7:0] e, g;
        clear_obs(); push_exp(7'h10, 4);
        pulse_start(7'h10, 8'd4);
        wait_done(200, cyc);
        n_checks++;
        if (cyc !== (CSUM_EN ? 14 : 13)) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles, want %0d", cyc, CSUM_EN ? 14 : 13);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b, want 0", bus.busy); end
        @(posedge clk); #1;
        n_checks++;
        if (acc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL basic_count: got %0d bytes, want %0d", acc_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && acc_q.size() > 0) begin
            e = exp_q.pop_front(); g = acc_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL basic_byte: got %h, want %h", g, e); end
        end
        n_checks++;
        if (done_cnt !== 1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: pulses=%0d busy=%b done=%b, want 1/0/0", done_cnt, bus.busy, bus.done);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [7:0] e, g;
        logic [6:0] ea, ga;
        clear_obs(); push_exp(7'h7E, 4);
        pulse_start(7'h7E, 8'd4);
        wait_done(200, cyc);
        @(posedge clk); #1;
        n_checks++;
        if (cyc === -1 || acc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL wrap_count: cyc=%0d got %0d bytes, want %0d", cyc, acc_q.size(), exp_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (acc_q.size() > 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); g = acc_q.pop_front();
                ea = exp_a.pop_front(); ga = addr_q.pop_front();
                n_checks++;
                if (g !== e || ga !== ea) begin
                    n_fail++; $display("FAIL wrap_byte: got %h@%h, want %h@%h", g, ga, e, ea);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit found, stable;
        logic [7:0] held, e, g;
        clear_obs(); push_exp(7'h20, 3);
        bus.tx_ready = 1'b0;
        pulse_start(7'h20, 8'd3);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1) begin found = 1'b1; break; end
        end
        held = bus.tx_data;
        n_checks++;
        if (!found || held !== 8'h7A) begin
            n_fail++; $display("FAIL bp_first: valid_seen=%b data=%h, want 1/7a", found, held);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== held) stable = 1'b0;
        end
        n_checks++;
        if (!stable || acc_q.size() !== 0) begin
            n_fail++; $display("FAIL bp_hold: stable=%b accepted=%0d, want 1/0", stable, acc_q.size());
        end
        @(posedge clk); #1;
        bus.tx_ready = 1'b1;
        wait_done(100, cyc);
        @(posedge clk); #1;
        n_checks++;
        if (cyc === -1 || acc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL bp_count: cyc=%0d got %0d bytes, want %0d", cyc, acc_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && acc_q.size() > 0) begin
            e = exp_q.pop_front(); g = acc_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL bp_byte: got %h, want %h", g, e); end
        end
    endtask

    task automatic test_count_edges();
        int cyc;
        logic [7:0] e, g;
        logic [6:0] ga;
        logic [127:0] seen;
        clear_obs(); push_exp(7'h05, 0);
        pulse_start(7'h05, 8'd0);
        wait_done(20, cyc);
        n_checks++;
        if (cyc !== (CSUM_EN ? 2 : 1)) begin
            n_fail++; $display("FAIL zero_latency: got %0d, want %0d", cyc, CSUM_EN ? 2 : 1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (valid_cyc !== (CSUM_EN ? 1 : 0) || busy_cyc !== (CSUM_EN ? 1 : 0) || acc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL zero_activity: valid=%0d busy=%0d bytes=%0d, want %0d/%0d/%0d",
                               valid_cyc, busy_cyc, acc_q.size(), CSUM_EN ? 1 : 0, CSUM_EN ? 1 : 0, exp_q.size());
        end
        while (exp_q.size() > 0 && acc_q.size() > 0) begin
            e = exp_q.pop_front(); g = acc_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL zero_byte: got %h, want %h", g, e); end
        end

        clear_obs(); push_exp(7'h33, 128);
        pulse_start(7'h33, 8'd200);
        wait_done(1000, cyc);
        @(posedge clk); #1;
        n_checks++;
        if (cyc === -1 || acc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL clamp_count: cyc=%0d got %0d bytes, want %0d", cyc, acc_q.size(), exp_q.size());
        end
        seen = '0;
        for (int i = 0; i < 128; i++) begin
            if (acc_q.size() > 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); g = acc_q.pop_front(); ga = addr_q.pop_front();
                seen[ga] = 1'b1;
                n_checks++;
                if (g !== e) begin n_fail++; $display("FAIL clamp_byte %0d: got %h, want %h", i, g, e); end
            end
        end
        n_checks++;
        if (seen !== {128{1'b1}}) begin n_fail++; $display("FAIL clamp_coverage: got %h, want all ones", seen); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0] e, g;
        clear_obs(); push_exp(7'h40, 8);
        pulse_start(7'h40, 8'd8);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.start_ptr = 7'h00; bus.count = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(200, cyc);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (cyc === -1 || done_cnt !== 1 || acc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL restart_ignored: cyc=%0d done=%0d bytes=%0d, want done 1 bytes %0d",
                               cyc, done_cnt, acc_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && acc_q.size() > 0) begin
            e = exp_q.pop_front(); g = acc_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL restart_byte: got %h, want %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit found;
        logic [7:0] e, g;
        clear_obs();
        bus.tx_ready = 1'b0;
        pulse_start(7'h50, 8'd5);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1) begin found = 1'b1; break; end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!found || bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: sent=%b valid=%b busy=%b done=%b, want 1/0/0/0",
                               found, bus.tx_valid, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        bus.tx_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt !== 0 || acc_q.size() !== 0) begin
            n_fail++; $display("FAIL rst_quiet: done=%0d bytes=%0d, want 0/0", done_cnt, acc_q.size());
        end
        clear_obs(); push_exp(7'h10, 2);
        pulse_start(7'h10, 8'd2);
        wait_done(100, cyc);
        @(posedge clk); #1;
        n_checks++;
        if (cyc === -1 || acc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rst_recover: cyc=%0d bytes=%0d, want %0d", cyc, acc_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && acc_q.size() > 0) begin
            e = exp_q.pop_front(); g = acc_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rst_recover_byte: got %h, want %h", g, e); end
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (overlap !== 0) begin n_fail++; $display("FAIL busy_done_overlap: got %0d cycles, want 0", overlap); end
    endtask

    initial begin
        bus.start = 1'b0; bus.start_ptr = 7'h00; bus.count = 8'd0; bus.tx_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_count_edges();
        test_back_to_back();
        test_reset_mid();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule
